// File: rtl/enemy_shooter.sv
// Enemy projectile engine: accepts fire requests, flies up to bullets_p bullets
// downward one step per frame, and pulses player_was_hit_o when one lands on the player.
module enemy_shooter #(
    parameter int bullets_p    = 3,
    parameter int speed_p      = 4,
    parameter int cooldown_p   = 30,
    parameter int bullet_w_p   = 2,
    parameter int bullet_h_p   = 8,
    parameter int player_top_p = 440,
    parameter int player_bot_p = 455,
    parameter int floor_p      = 479
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    frame_i,
    input  logic                    enable_i,
    input  logic [9:0]              p_left_i,
    input  logic [9:0]              p_right_i,
    input  logic                    fire_valid_i,
    input  logic [9:0]              fire_x_i,
    input  logic [9:0]              fire_y_i,
    output logic                    fire_ready_o,
    output logic [bullets_p-1:0]    bullet_active_o,
    output logic [10*bullets_p-1:0] bullet_x_o,
    output logic [10*bullets_p-1:0] bullet_y_o,
    output logic                    player_was_hit_o
);

    localparam int CW = (cooldown_p > 1) ? $clog2(cooldown_p + 1) : 1;

    typedef enum logic {IDLE = 1'b0, FLYING = 1'b1} slot_state_e;

    // Handshake: a shot is taken on a rising edge where fire_valid_i && fire_ready_o;
    // fire_ready_o depends only on registered state and enable_i, never on fire_valid_i.
    slot_state_e          state_q [bullets_p];
    slot_state_e          state_d [bullets_p];
    logic [9:0]           x_q [bullets_p];
    logic [9:0]           x_d [bullets_p];
    logic [9:0]           y_q [bullets_p];
    logic [9:0]           y_d [bullets_p];
    logic [10:0]          yn [bullets_p];
    logic [CW-1:0]        cool_q, cool_d;
    logic                 hit_q, hit_d;
    logic [bullets_p-1:0] hit_w, off_w, idle_w, alloc_vec;
    logic                 found, accept;

    for (genvar gi = 0; gi < bullets_p; gi++) begin : g_slot
        // 11-bit step so a bullet near the bottom cannot wrap back to the top
        assign yn[gi]     = {1'b0, y_q[gi]} + 11'(speed_p);
        assign hit_w[gi]  = (state_q[gi] == FLYING)
                          && (12'(yn[gi]) + 12'(bullet_h_p - 1) >= 12'(player_top_p))
                          && (yn[gi] <= 11'(player_bot_p))
                          && (x_q[gi] <= p_right_i)
                          && ({1'b0, x_q[gi]} + 11'(bullet_w_p - 1) >= {1'b0, p_left_i});
        assign off_w[gi]  = (state_q[gi] == FLYING) && (yn[gi] > 11'(floor_p));
        assign idle_w[gi] = (state_q[gi] == IDLE);
        assign bullet_active_o[gi]        = (state_q[gi] == FLYING);
        assign bullet_x_o[10*gi +: 10]    = x_q[gi];
        assign bullet_y_o[10*gi +: 10]    = y_q[gi];
    end

    assign fire_ready_o     = enable_i && (cool_q == '0) && (|idle_w);
    assign accept           = fire_valid_i && fire_ready_o;
    assign player_was_hit_o = hit_q;

    always_comb begin
        found     = 1'b0;
        alloc_vec = '0;
        for (int i = 0; i < bullets_p; i++) begin
            if (!found && idle_w[i]) begin
                alloc_vec[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cool_d  = cool_q;
        hit_d   = 1'b0;
        if (!enable_i) begin
            for (int i = 0; i < bullets_p; i++) state_d[i] = IDLE;
            cool_d = '0;
        end else begin
            if (accept) begin
                cool_d = CW'(cooldown_p);
            end else if (frame_i && (cool_q != '0)) begin
                cool_d = cool_q - CW'(1);
            end
            for (int i = 0; i < bullets_p; i++) begin
                if (frame_i && (state_q[i] == FLYING)) begin
                    if (hit_w[i] || off_w[i]) state_d[i] = IDLE;
                    else                      y_d[i]     = yn[i][9:0];
                end
                // allocated slot was IDLE before the edge, so it is never moved here
                if (accept && alloc_vec[i]) begin
                    state_d[i] = FLYING;
                    x_d[i]     = fire_x_i;
                    y_d[i]     = fire_y_i;
                end
            end
            hit_d = frame_i && (|hit_w);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < bullets_p; i++) begin
                state_q[i] <= IDLE;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
            end
            cool_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cool_q  <= cool_d;
            hit_q   <= hit_d;
        end
    end

endmodule

// File: tb/tb_enemy_shooter.sv
// Directed bench for enemy_shooter: firing, flight, hit, floor, pool-full,
// simultaneous events, flush and asynchronous reset.
module tb_enemy_shooter;

    logic        clk_i = 1'b0;
    logic        reset_i, frame_i, enable_i, fire_valid_i;
    logic [9:0]  p_left_i, p_right_i, fire_x_i, fire_y_i;
    logic        fire_ready_o, player_was_hit_o;
    logic [2:0]  bullet_active_o;
    logic [29:0] bullet_x_o, bullet_y_o;

    int checks   = 0;
    int errors   = 0;
    int hits_cnt = 0;

    enemy_shooter u_dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .frame_i          (frame_i),
        .enable_i         (enable_i),
        .p_left_i         (p_left_i),
        .p_right_i        (p_right_i),
        .fire_valid_i     (fire_valid_i),
        .fire_x_i         (fire_x_i),
        .fire_y_i         (fire_y_i),
        .fire_ready_o     (fire_ready_o),
        .bullet_active_o  (bullet_active_o),
        .bullet_x_o       (bullet_x_o),
        .bullet_y_o       (bullet_y_o),
        .player_was_hit_o (player_was_hit_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (player_was_hit_o === 1'b1) hits_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] bx(input int i);
        return bullet_x_o[10*i +: 10];
    endfunction

    function automatic logic [9:0] by(input int i);
        return bullet_y_o[10*i +: 10];
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_i = 1'b1;
            step();
            frame_i = 1'b0;
            step();
        end
    endtask

    task automatic fire_once(input logic [9:0] x, input logic [9:0] y);
        fire_x_i     = x;
        fire_y_i     = y;
        fire_valid_i = 1'b1;
        step();
        fire_valid_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b0; enable_i = 1'b0; frame_i = 1'b0; fire_valid_i = 1'b0;
        fire_x_i = '0; fire_y_i = '0; p_left_i = 10'd96; p_right_i = 10'd111;
        #2;
        check_eq("rst_ready_en0", 32'(fire_ready_o), 32'd0);
        enable_i = 1'b1;
        #1;
        check_eq("rst_ready_en1", 32'(fire_ready_o), 32'd1);
        check_eq("rst_active", 32'(bullet_active_o), 32'd0);
        check_eq("rst_x", 32'(bullet_x_o), 32'd0);
        check_eq("rst_y", 32'(bullet_y_o), 32'd0);
        check_eq("rst_hit", 32'(player_was_hit_o), 32'd0);
        step(); step();
        reset_i = 1'b1;
        step();

        // fire and fly, then hit
        fire_once(10'd100, 10'd50);
        check_eq("fire_active", 32'(bullet_active_o), 32'd1);
        check_eq("fire_x0", 32'(bx(0)), 32'd100);
        check_eq("fire_y0", 32'(by(0)), 32'd50);
        check_eq("fire_ready_cool", 32'(fire_ready_o), 32'd0);
        do_frames(3);
        check_eq("fly3_y0", 32'(by(0)), 32'd62);
        do_frames(26);
        check_eq("cool29_ready", 32'(fire_ready_o), 32'd0);
        do_frames(1);
        check_eq("cool30_ready", 32'(fire_ready_o), 32'd1);
        check_eq("fly30_y0", 32'(by(0)), 32'd170);
        do_frames(65);
        check_eq("fly95_y0", 32'(by(0)), 32'd430);
        check_eq("fly95_active", 32'(bullet_active_o), 32'd1);
        check_eq("prehit_cnt", 32'(hits_cnt), 32'd0);
        frame_i = 1'b1;
        step();
        check_eq("hit_pulse", 32'(player_was_hit_o), 32'd1);
        check_eq("hit_slot_idle", 32'(bullet_active_o), 32'd0);
        frame_i = 1'b0;
        step();
        check_eq("hit_pulse_end", 32'(player_was_hit_o), 32'd0);
        check_eq("hit_cnt1", 32'(hits_cnt), 32'd1);

        // miss and floor
        p_left_i = 10'd200; p_right_i = 10'd215;
        fire_once(10'd100, 10'd400);
        do_frames(19);
        check_eq("floor_y476", 32'(by(0)), 32'd476);
        check_eq("floor_active", 32'(bullet_active_o), 32'd1);
        do_frames(1);
        check_eq("floor_cleared", 32'(bullet_active_o), 32'd0);
        check_eq("floor_y_hold", 32'(by(0)), 32'd476);
        check_eq("miss_cnt", 32'(hits_cnt), 32'd1);
        do_frames(10);
        check_eq("miss_ready", 32'(fire_ready_o), 32'd1);

        // two hits on one frame, accept coincident with frame
        p_left_i = 10'd96; p_right_i = 10'd111;
        fire_once(10'd100, 10'd200);
        do_frames(30);
        check_eq("sim_y0", 32'(by(0)), 32'd320);
        fire_x_i = 10'd104; fire_y_i = 10'd324; fire_valid_i = 1'b1; frame_i = 1'b1;
        step();
        fire_valid_i = 1'b0; frame_i = 1'b0;
        check_eq("coinc_active", 32'(bullet_active_o), 32'd3);
        check_eq("coinc_y1_unmoved", 32'(by(1)), 32'd324);
        check_eq("coinc_y0_moved", 32'(by(0)), 32'd324);
        check_eq("coinc_x1", 32'(bx(1)), 32'd104);
        do_frames(27);
        check_eq("pair_y432", 32'(by(1)), 32'd432);
        frame_i = 1'b1;
        step();
        check_eq("pair_hit_pulse", 32'(player_was_hit_o), 32'd1);
        check_eq("pair_idle", 32'(bullet_active_o), 32'd0);
        frame_i = 1'b0;
        step();
        check_eq("pair_one_pulse", 32'(hits_cnt), 32'd2);
        do_frames(1);
        check_eq("coinc_cool_full", 32'(fire_ready_o), 32'd0);
        do_frames(1);
        check_eq("coinc_cool_done", 32'(fire_ready_o), 32'd1);

        // pool full with held request
        p_left_i = 10'd600; p_right_i = 10'd615;
        fire_x_i = 10'd50; fire_y_i = 10'd100; fire_valid_i = 1'b1;
        step();
        check_eq("pool_s0", 32'(bullet_active_o), 32'd1);
        do_frames(30);
        check_eq("pool_s1", 32'(bullet_active_o), 32'd3);
        check_eq("pool_y1", 32'(by(1)), 32'd100);
        check_eq("pool_y0", 32'(by(0)), 32'd220);
        do_frames(30);
        check_eq("pool_s2", 32'(bullet_active_o), 32'd7);
        check_eq("pool_y2", 32'(by(2)), 32'd100);
        do_frames(30);
        check_eq("pool_full_ready", 32'(fire_ready_o), 32'd0);
        check_eq("pool_full_active", 32'(bullet_active_o), 32'd7);
        check_eq("pool_y0_460", 32'(by(0)), 32'd460);
        do_frames(4);
        frame_i = 1'b1;
        step();
        frame_i = 1'b0;
        check_eq("pool_free_active", 32'(bullet_active_o), 32'd6);
        check_eq("pool_free_ready", 32'(fire_ready_o), 32'd1);
        step();
        fire_valid_i = 1'b0;
        check_eq("pool_refill", 32'(bullet_active_o), 32'd7);
        check_eq("pool_refill_y0", 32'(by(0)), 32'd100);
        check_eq("pool_refill_ready", 32'(fire_ready_o), 32'd0);
        check_eq("pool_hit_cnt", 32'(hits_cnt), 32'd2);

        // flush while a bullet would hit on this frame
        do_frames(18);
        check_eq("flush_pre_y1", 32'(by(1)), 32'd432);
        p_left_i = 10'd40; p_right_i = 10'd60;
        enable_i = 1'b0; frame_i = 1'b1;
        step();
        frame_i = 1'b0;
        check_eq("flush_active", 32'(bullet_active_o), 32'd0);
        check_eq("flush_no_hit", 32'(player_was_hit_o), 32'd0);
        check_eq("flush_ready", 32'(fire_ready_o), 32'd0);
        step();
        check_eq("flush_cnt", 32'(hits_cnt), 32'd2);
        enable_i = 1'b1;
        #1;
        check_eq("flush_cool_clr", 32'(fire_ready_o), 32'd1);

        // asynchronous reset with a hit pulse pending
        p_left_i = 10'd96; p_right_i = 10'd111;
        fire_once(10'd100, 10'd420);
        do_frames(3);
        check_eq("rmid_y432", 32'(by(0)), 32'd432);
        frame_i = 1'b1;
        step();
        frame_i = 1'b0;
        check_eq("rmid_hit", 32'(player_was_hit_o), 32'd1);
        reset_i = 1'b0;
        #1;
        check_eq("rmid_hit_clr", 32'(player_was_hit_o), 32'd0);
        check_eq("rmid_active", 32'(bullet_active_o), 32'd0);
        check_eq("rmid_x", 32'(bullet_x_o), 32'd0);
        check_eq("rmid_y", 32'(bullet_y_o), 32'd0);
        check_eq("rmid_ready", 32'(fire_ready_o), 32'd1);
        step();
        check_eq("rmid_cnt", 32'(hits_cnt), 32'd2);
        reset_i = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
